latch_wr_sequencer: RTL and testbench
=====================================

Name: latch_wr_sequencer

Overview:
- Write-strobe sequencer that feeds a bank of negative-enable D latches (9T dlatn cells), forming a latch-based register file.
- Accepts single-word write requests over a valid/ready handshake and drives the shared latch D bus.
- Generates a registered, glitch-free active-low enable pulse to exactly one latch word.
- Guarantees programmable setup, pulse-width and hold margins in whole clock cycles.

Parameters:
- ADDR_W, 3, word address width; NWORDS = 2**ADDR_W latch words.
- DATA_W, 8, data width per word.
- SETUP_CYC, 1, cycles lat_d is stable before the enable falls; must be >= 1.
- PULSE_CYC, 1, cycles the enable is held low; must be >= 1.
- HOLD_CYC, 1, cycles lat_d is stable after the enable rises; must be >= 1.

Ports:
- CLK  input  1  clock, rising-edge active.
- RN  input  1  asynchronous active-low reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  sequencer can accept a request.
- req_addr  input  ADDR_W  target word.
- req_data  input  DATA_W  write data.
- lat_d  output  DATA_W  shared D bus to all latch words.
- lat_clkn  output  NWORDS  per-word active-low latch enable; idle high.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a write completes.

Behaviour:
- Interface:
  - One clock, CLK. Reset RN is asynchronous and active-low.
  - All outputs are driven from flops; there are no combinational paths from inputs to outputs.
- Reset (RN low, asynchronous, at any time including mid-write):
  - state = IDLE, lat_clkn = all ones, lat_d = 0, req_ready = 1, busy = 0, done = 0, counter = 0.
  - After RN deasserts, the first possible accept is at the first rising CLK edge.
- States:
  - IDLE: req_ready = 1. On req_valid at a rising edge (edge T0): latch req_addr into addr_q, load req_data onto lat_d, load the counter with SETUP_CYC-1, go to SETUP.
  - SETUP: when the counter reaches 0, drive lat_clkn[addr_q] = 0, load PULSE_CYC-1, go to STROBE. The enable falls at edge T0+SETUP_CYC.
  - STROBE: when the counter reaches 0, drive lat_clkn = all ones, load HOLD_CYC-1, go to HOLD. The enable rises at edge T0+SETUP_CYC+PULSE_CYC.
  - HOLD: when the counter reaches 0, set done = 1 for one cycle, set req_ready = 1, go to IDLE. This happens at edge T0+S+P+H.
- Timing and throughput:
  - Earliest next accept is edge T0+S+P+H+1, giving one write per S+P+H+1 cycles (4 cycles with default parameters).
- Invariants:
  - lat_d changes only on an accept edge, and holds its last value in IDLE.
  - At most one lat_clkn bit is low at any time (except under the optional broadcast feature).
  - lat_clkn never toggles in the same cycle as lat_d.
- Input handling:
  - req_valid, req_addr and req_data are ignored while req_ready = 0. There is no queueing.
  - Request inputs may change freely after acceptance.
- Counter:
  - Width is $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1). It decrements and saturates at 0.
- Parameter checks:
  - Any of SETUP_CYC, PULSE_CYC or HOLD_CYC equal to 0 is an elaboration-time error.

Optional Feature:
- Macro: LATCH_WR_SEQUENCER_BCAST_EN.
- Defined:
  - Adds input port req_bcast (1 bit), sampled together with the request on accept.
  - If req_bcast = 1, STROBE drives all lat_clkn bits low together, writing req_data to every word. req_addr is ignored.
  - Timing is identical to a single-word write.
- Undefined:
  - The port does not exist, and exactly one enable bit is ever asserted.

Test Plan:
- Reset mid-strobe: assert RN low while lat_clkn[2] = 0 -> lat_clkn = 8'hFF, lat_d = 0, req_ready = 1 asynchronously, with no done pulse.
- Default timing: accept addr=5, data=8'hA5 at edge T0 -> lat_d = A5 from T0, lat_clkn = 8'hDF during [T1,T2), done high for [T3,T4), req_ready high from T3.
- Stretched margins: SETUP=3, PULSE=2, HOLD=4, write addr=0 -> enable low at edges T3..T5, done at T9, and lat_d constant from T0 through T9.
- Back-to-back: req_valid held high with 4 writes to addr 0..3 -> accepts at T0, T4, T8, T12, and the enables never overlap.
- Ignored request: toggle req_valid/req_addr/req_data during STROBE -> the active enable and lat_d are unchanged, and no extra accept occurs.
- With LATCH_WR_SEQUENCER_BCAST_EN: req_bcast=1, data=8'h3C -> lat_clkn = 8'h00 for exactly PULSE_CYC cycles; without the macro, a scoreboard confirms at most one enable bit is low at any time.

Source files
------------

// File: rtl/latch_wr_sequencer.sv
// Write-strobe sequencer for a latch-based register file: one word per request with
// cycle-exact setup/pulse/hold margins. Broadcast writes enabled by LATCH_WR_SEQUENCER_BCAST_EN.
module latch_wr_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1,
    localparam int NWORDS   = 32'd1 << ADDR_W
) (
    input  logic              CLK,
    input  logic              RN,
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
    input  logic              req_bcast,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [DATA_W-1:0] lat_d,
    output logic [NWORDS-1:0] lat_clkn,
    output logic              busy,
    output logic              done
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 32'sd1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 32'sd1);

    if (SETUP_CYC < 32'sd1 || PULSE_CYC < 32'sd1 || HOLD_CYC < 32'sd1) begin : g_bad_cyc
        $error("latch_wr_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] lat_d_r, lat_d_s;
    logic [NWORDS-1:0] lat_clkn_r, lat_clkn_s;
    logic              ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              bcast_r, bcast_s;

    // Active-low one-hot enable pattern selecting a single latch word.
    function automatic logic [NWORDS-1:0] word_enable_n(input logic [ADDR_W-1:0] addr);
        logic [NWORDS-1:0] onehot;
        onehot = {{(NWORDS-1){1'b0}}, 1'b1} << addr;
        return ~onehot;
    endfunction

    // Next-state and next-output decode; every output is taken from a flop below.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        addr_s     = addr_r;
        lat_d_s    = lat_d_r;
        lat_clkn_s = lat_clkn_r;
        ready_s    = ready_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bcast_s    = bcast_r;
        case (state_r)
            IDLE: begin
                lat_clkn_s = '1;
                if (req_valid) begin
                    addr_s  = req_addr;
                    lat_d_s = req_data;
                    cnt_s   = SETUP_LD;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                    state_s = SETUP;
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
                    bcast_s = req_bcast;
`else
                    bcast_s = 1'b0;
`endif
                end else begin
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_r == '0) begin
                    lat_clkn_s = bcast_r ? '0 : word_enable_n(addr_r);
                    cnt_s      = PULSE_LD;
                    state_s    = STROBE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt_r == '0) begin
                    lat_clkn_s = '1;
                    cnt_s      = HOLD_LD;
                    state_s    = HOLD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == '0) begin
                    done_s  = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                lat_clkn_s = '1;
                cnt_s      = '0;
                ready_s    = 1'b1;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // State and output registers; reset parks every latch enable high.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            addr_r     <= '0;
            lat_d_r    <= '0;
            lat_clkn_r <= '1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcast_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            lat_d_r    <= lat_d_s;
            lat_clkn_r <= lat_clkn_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bcast_r    <= bcast_s;
        end
    end

    assign req_ready = ready_r;
    assign lat_d     = lat_d_r;
    assign lat_clkn  = lat_clkn_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Bench for latch_wr_sequencer: a default-margin instance and a stretched (3/2/4) instance share
// stimulus; outputs are compared with a cycles-since-accept reference model.
module tb_latch_wr_sequencer;

    logic       CLK = 1'b0;
    logic       RN;
    logic       req_valid;
    logic [2:0] req_addr;
    logic [7:0] req_data;
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
    logic       req_bcast;
`endif
    logic [7:0] lat_d_w  [2];
    logic [7:0] clkn_w   [2];
    logic       ready_w  [2];
    logic       busy_w   [2];
    logic       done_w   [2];

    int n_checks = 0;
    int n_pass   = 0;

    // model: cycles since the last accept (-1 = nothing since reset) plus captured request
    int         mk    [2];
    logic [2:0] maddr [2];
    logic [7:0] mdata [2];
    logic       mbc   [2];
    int         ms    [2] = '{1, 3};
    int         mp    [2] = '{1, 2};
    int         mh    [2] = '{1, 4};

    always #5 CLK = ~CLK;

    latch_wr_sequencer u_dut0 (
        .CLK(CLK), .RN(RN),
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
        .req_bcast(req_bcast),
`endif
        .req_valid(req_valid), .req_ready(ready_w[0]), .req_addr(req_addr), .req_data(req_data),
        .lat_d(lat_d_w[0]), .lat_clkn(clkn_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    latch_wr_sequencer #(.SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(4)) u_dut1 (
        .CLK(CLK), .RN(RN),
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
        .req_bcast(req_bcast),
`endif
        .req_valid(req_valid), .req_ready(ready_w[1]), .req_addr(req_addr), .req_data(req_data),
        .lat_d(lat_d_w[1]), .lat_clkn(clkn_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    function automatic int len(input int i);
        return ms[i] + mp[i] + mh[i];
    endfunction

    function automatic logic e_ready(input int i);
        return (mk[i] < 0) || (mk[i] >= len(i));
    endfunction

    function automatic logic e_done(input int i);
        return mk[i] == len(i);
    endfunction

    function automatic logic [7:0] e_clkn(input int i);
        logic [7:0] one = 8'h01;
        if (mk[i] >= ms[i] && mk[i] < ms[i] + mp[i])
            return mbc[i] ? 8'h00 : ~(one << maddr[i]);
        return 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mk[i] = -1; maddr[i] = 3'd0; mdata[i] = 8'h00; mbc[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (!RN) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (e_ready(i) && req_valid) begin
                    mk[i] = 0; maddr[i] = req_addr; mdata[i] = req_data;
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
                    mbc[i] = req_bcast;
`else
                    mbc[i] = 1'b0;
`endif
                end else if (mk[i] >= 0 && mk[i] <= len(i)) begin
                    mk[i]++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        int t = 0;
        req_valid = 1'b0;
        while (!(ready_w[0] && ready_w[1]) && t < 40) begin
            cyc();
            t++;
        end
        n_checks++;
        if (!(ready_w[0] && ready_w[1]))
            $display("FAIL wait_idle: ready=%b%b expected 11", ready_w[0], ready_w[1]);
        else n_pass++;
    endtask

    task automatic test_reset();
        RN = 1'b0; req_valid = 1'b0; req_addr = 3'd0; req_data = 8'h00;
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
        req_bcast = 1'b0;
`endif
        model_reset();
        cyc(); cyc();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (clkn_w[i] !== 8'hFF) $display("FAIL rst_clkn%0d: got %h expected ff", i, clkn_w[i]);
            else n_pass++;
            n_checks++;
            if (lat_d_w[i] !== 8'h00) $display("FAIL rst_d%0d: got %h expected 00", i, lat_d_w[i]);
            else n_pass++;
            n_checks++;
            if ({ready_w[i], busy_w[i], done_w[i]} !== 3'b100)
                $display("FAIL rst_flags%0d: rdy/busy/done got %b%b%b expected 100",
                         i, ready_w[i], busy_w[i], done_w[i]);
            else n_pass++;
        end
        RN = 1'b1;
    endtask

    task automatic test_default_timing();
        logic [7:0] xc;
        wait_idle();
        req_valid = 1'b1; req_addr = 3'd5; req_data = 8'hA5;
        for (int t = 0; t < 5; t++) begin
            cyc();
            req_valid = 1'b0; req_addr = 3'd0; req_data = 8'h00;
            xc = (t == 1) ? 8'hDF : 8'hFF;
            n_checks++;
            if (clkn_w[0] !== xc) $display("FAIL dflt_clkn t=%0d: got %h expected %h", t, clkn_w[0], xc);
            else n_pass++;
            n_checks++;
            if (lat_d_w[0] !== 8'hA5) $display("FAIL dflt_d t=%0d: got %h expected a5", t, lat_d_w[0]);
            else n_pass++;
            n_checks++;
            if (done_w[0] !== (t == 3)) $display("FAIL dflt_done t=%0d: got %b expected %b", t, done_w[0], t == 3);
            else n_pass++;
            n_checks++;
            if (ready_w[0] !== (t >= 3)) $display("FAIL dflt_ready t=%0d: got %b expected %b", t, ready_w[0], t >= 3);
            else n_pass++;
        end
    endtask

    task automatic test_stretched();
        logic [7:0] r = 8'($urandom);
        logic [7:0] xc;
        wait_idle();
        req_valid = 1'b1; req_addr = 3'd0; req_data = r;
        for (int t = 0; t < 11; t++) begin
            cyc();
            req_valid = 1'b0; req_data = ~r;
            xc = (t >= 3 && t < 5) ? 8'hFE : 8'hFF;
            n_checks++;
            if (clkn_w[1] !== xc) $display("FAIL str_clkn t=%0d: got %h expected %h", t, clkn_w[1], xc);
            else n_pass++;
            n_checks++;
            if (done_w[1] !== (t == 9)) $display("FAIL str_done t=%0d: got %b expected %b", t, done_w[1], t == 9);
            else n_pass++;
            n_checks++;
            if (lat_d_w[1] !== r) $display("FAIL str_d t=%0d: got %h expected %h", t, lat_d_w[1], r);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bd [4];
        logic [7:0] one = 8'h01;
        logic [7:0] xc;
        for (int j = 0; j < 4; j++) bd[j] = 8'($urandom);
        wait_idle();
        req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            req_addr = 3'(c / 4); req_data = bd[c / 4];
            cyc();
            xc = (c % 4 == 1) ? ~(one << (c / 4)) : 8'hFF;
            n_checks++;
            if (clkn_w[0] !== xc) $display("FAIL b2b_clkn c=%0d: got %h expected %h", c, clkn_w[0], xc);
            else n_pass++;
            n_checks++;
            if (lat_d_w[0] !== bd[c / 4]) $display("FAIL b2b_d c=%0d: got %h expected %h", c, lat_d_w[0], bd[c / 4]);
            else n_pass++;
            n_checks++;
            if (ready_w[0] !== (c % 4 == 3)) $display("FAIL b2b_ready c=%0d: got %b expected %b", c, ready_w[0], c % 4 == 3);
            else n_pass++;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_ignored();
        logic [7:0] r0 = 8'($urandom);
        wait_idle();
        req_valid = 1'b1; req_addr = 3'd6; req_data = r0;
        cyc();
        req_valid = 1'b0;
        cyc();
        req_valid = 1'b1; req_addr = 3'd1; req_data = ~r0;
        #1;
        n_checks++;
        if ({clkn_w[0], lat_d_w[0]} !== {8'hBF, r0})
            $display("FAIL ign_strobe: clkn/d got %h/%h expected bf/%h", clkn_w[0], lat_d_w[0], r0);
        else n_pass++;
        cyc();
        req_addr = 3'd3; req_data = r0 ^ 8'h55;
        n_checks++;
        if ({clkn_w[0], lat_d_w[0], busy_w[0]} !== {8'hFF, r0, 1'b1})
            $display("FAIL ign_hold: clkn/d/busy got %h/%h/%b expected ff/%h/1", clkn_w[0], lat_d_w[0], busy_w[0], r0);
        else n_pass++;
        cyc();
        req_valid = 1'b0;
        n_checks++;
        if ({done_w[0], lat_d_w[0]} !== {1'b1, r0})
            $display("FAIL ign_done: done/d got %b/%h expected 1/%h", done_w[0], lat_d_w[0], r0);
        else n_pass++;
        cyc();
        n_checks++;
        if ({busy_w[0], done_w[0], lat_d_w[0]} !== {1'b0, 1'b0, r0})
            $display("FAIL ign_noaccept: busy/done/d got %b/%b/%h expected 0/0/%h", busy_w[0], done_w[0], lat_d_w[0], r0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wait_idle();
        req_valid = 1'b1; req_addr = 3'd2; req_data = 8'h5A;
        cyc();
        req_valid = 1'b0;
        cyc();
        n_checks++;
        if (clkn_w[0] !== 8'hFB) $display("FAIL rmid_pre: clkn got %h expected fb", clkn_w[0]);
        else n_pass++;
        #1 RN = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({clkn_w[i], lat_d_w[i], ready_w[i], busy_w[i], done_w[i]} !== {8'hFF, 8'h00, 3'b100})
                $display("FAIL rmid_async%0d: clkn/d/rdy/busy/done got %h/%h/%b%b%b expected ff/00/100",
                         i, clkn_w[i], lat_d_w[i], ready_w[i], busy_w[i], done_w[i]);
            else n_pass++;
        end
        cyc();
        n_checks++;
        if (done_w[0] !== 1'b0) $display("FAIL rmid_done: got %b expected 0", done_w[0]);
        else n_pass++;
        RN = 1'b1;
    endtask

    task automatic test_random();
        int zeros;
        logic ok;
        for (int c = 0; c < 300; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 3'($urandom);
            req_data  = 8'($urandom);
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
            req_bcast = ($urandom_range(0, 7) == 0);
`endif
            cyc();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (clkn_w[i] !== e_clkn(i)) $display("FAIL rnd_clkn%0d c=%0d: got %h expected %h", i, c, clkn_w[i], e_clkn(i));
                else n_pass++;
                n_checks++;
                if (lat_d_w[i] !== mdata[i]) $display("FAIL rnd_d%0d c=%0d: got %h expected %h", i, c, lat_d_w[i], mdata[i]);
                else n_pass++;
                n_checks++;
                if (ready_w[i] !== e_ready(i)) $display("FAIL rnd_ready%0d c=%0d: got %b expected %b", i, c, ready_w[i], e_ready(i));
                else n_pass++;
                n_checks++;
                if (busy_w[i] !== !e_ready(i)) $display("FAIL rnd_busy%0d c=%0d: got %b expected %b", i, c, busy_w[i], !e_ready(i));
                else n_pass++;
                n_checks++;
                if (done_w[i] !== e_done(i)) $display("FAIL rnd_done%0d c=%0d: got %b expected %b", i, c, done_w[i], e_done(i));
                else n_pass++;
                zeros = $countones(~clkn_w[i]);
                ok = (zeros <= 1);
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
                ok = ok || (zeros == 8);
`endif
                n_checks++;
                if (!ok) $display("FAIL rnd_onehot%0d c=%0d: enables low=%0d expected <=1", i, c, zeros);
                else n_pass++;
            end
        end
        req_valid = 1'b0;
    endtask

`ifdef LATCH_WR_SEQUENCER_BCAST_EN
    task automatic test_bcast();
        int low_cnt [2] = '{0, 0};
        wait_idle();
        req_valid = 1'b1; req_bcast = 1'b1; req_addr = 3'd4; req_data = 8'h3C;
        for (int t = 0; t < 10; t++) begin
            cyc();
            req_valid = 1'b0; req_bcast = 1'b0;
            for (int i = 0; i < 2; i++) if (clkn_w[i] === 8'h00) low_cnt[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (low_cnt[i] != mp[i]) $display("FAIL bcast_pulse%0d: cycles all-low got %0d expected %0d", i, low_cnt[i], mp[i]);
            else n_pass++;
            n_checks++;
            if (lat_d_w[i] !== 8'h3C) $display("FAIL bcast_d%0d: got %h expected 3c", i, lat_d_w[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_timing();
        test_stretched();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_random();
`ifdef LATCH_WR_SEQUENCER_BCAST_EN
        test_bcast();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
